user_stream_arbiter: RTL
========================

# user_stream_arbiter

Packet-granular two-input stream arbiter for the user logic region. It merges the host sink stream (input 0) and the card sink stream (input 1) into a single downstream stream for a shared user datapath, and tags each beat with its source. A grant is held for a whole packet, so packets are never interleaved. The output passes through one registered stage.

## Interface
Parameters:
- DATA_BITS, 512, tdata width; tkeep width is DATA_BITS/8.

Ports:
- aclk  in  1  single clock; all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- prio_mode  in  1  0 = round-robin, 1 = fixed priority to input 0; sampled only in IDLE
- s0_tdata / s0_tkeep / s0_tlast / s0_tvalid  in  DATA_BITS / DATA_BITS/8 / 1 / 1  input 0 (host) stream
- s0_tready  out  1  input 0 ready
- s1_tdata / s1_tkeep / s1_tlast / s1_tvalid  in  DATA_BITS / DATA_BITS/8 / 1 / 1  input 1 (card) stream
- s1_tready  out  1  input 1 ready
- m_tdata / m_tkeep / m_tlast  out  DATA_BITS / DATA_BITS/8 / 1  merged output beat
- m_tid  out  1  source of the current beat (0 = s0, 1 = s1)
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- pkt_cnt0 / pkt_cnt1  out  32  packets completed per input (see Configuration)

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT0: s0 owns the output.
  - GRANT1: s1 owns the output.
- IDLE transitions:
  - Only one tvalid asserted: grant that input.
  - Both asserted, prio_mode=1: GRANT0.
  - Both asserted, prio_mode=0: grant the input selected by rr_ptr.
  - Neither asserted: stay in IDLE.
- rr_ptr (1 bit, reset 0) names the preferred input. On packet completion from input i, rr_ptr becomes ~i. rr_ptr is updated in both prio modes.
- GRANTi: sN_tready = (N==i) && (!m_tvalid || m_tready). The non-granted input's tready is 0.
- A beat is accepted when sN_tvalid && sN_tready. On acceptance, tdata, tkeep and tlast load into the output register, m_tid <= i, and m_tvalid <= 1.
- If m_tvalid && m_tready and no new beat is accepted, m_tvalid <= 0.
- An accepted beat with tlast=1 ends the grant: FSM goes to IDLE next cycle and rr_ptr updates.
- A single-beat packet (tlast on the first beat) is legal: one accepted beat, then IDLE.
- prio_mode changes during GRANTx have no effect until IDLE.
- Output register contents hold while m_tvalid && !m_tready; upstream tready is 0 in that cycle.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - FSM = IDLE, rr_ptr = 0.
  - m_tvalid = 0, m_tdata = 0, m_tkeep = 0, m_tlast = 0, m_tid = 0.
  - s0_tready = s1_tready = 0.
  - pkt_cnt0 = pkt_cnt1 = 0.
- Reset mid-packet: the packet is abandoned and the output register is cleared; no recovery of partial packets.
- Latency: a beat accepted at edge N is presented on m_* from edge N until accepted downstream.
- Arbitration: the first grant takes 1 cycle in IDLE, so the first beat is accepted on the cycle after tvalid is seen.
- Between packets: exactly one idle cycle (the IDLE state) at the input side. Sustained output is 1 beat/cycle within a packet.
- s*_tready depends combinationally on m_tready; there is no combinational path from s*_tvalid to any output.

## Configuration
- USER_ARB_PKT_CNT_EN:
  - Defined: pkt_cnt0 and pkt_cnt1 are 32-bit registers. pkt_cntI increments on each accepted tlast beat from input I and wraps 0xFFFFFFFF -> 0.
  - Undefined: no counter logic; pkt_cnt0 and pkt_cnt1 are driven constant 0.

## Test plan
- Single source: s0 sends a 4-beat packet with data 0x1..0x4, m_tready=1 -> m_* carries 0x1..0x4 with m_tid=0, m_tlast on beat 4, s1_tready=0 throughout.
- Round-robin contention: both inputs continuously offer 2-beat packets, prio_mode=0 -> output order s0, s1, s0, s1, with no interleaving inside a packet and one bubble between packets.
- Fixed priority: same stimulus with prio_mode=1 -> only s0 packets are granted while s0_tvalid is continuously high; s1 is granted only after s0 deasserts.
- Backpressure: m_tready=0 for 5 cycles mid-packet -> m_tdata stable, granted tready=0; after release the remaining beats arrive without loss or duplication.
- Reset mid-packet: assert aresetn=0 after beat 2 of 4 -> all outputs at reset values immediately, FSM in IDLE, a new packet from s1 is then granted first cycle after IDLE.
- Counters (USER_ARB_PKT_CNT_EN defined): preload via 3 s0 packets and 2 s1 packets -> pkt_cnt0=3, pkt_cnt1=2. With the macro undefined, both read 0.

Source files
------------

// File: rtl/user_stream_arbiter.sv
// Packet-granular two-input stream arbiter with one registered output stage.
// Define USER_ARB_PKT_CNT_EN to build the per-input completed-packet counters.
module user_stream_arbiter #(
  parameter int DATA_BITS = 512
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   prio_mode,
  input  logic [DATA_BITS-1:0]   s0_tdata,
  input  logic [DATA_BITS/8-1:0] s0_tkeep,
  input  logic                   s0_tlast,
  input  logic                   s0_tvalid,
  output logic                   s0_tready,
  input  logic [DATA_BITS-1:0]   s1_tdata,
  input  logic [DATA_BITS/8-1:0] s1_tkeep,
  input  logic                   s1_tlast,
  input  logic                   s1_tvalid,
  output logic                   s1_tready,
  output logic [DATA_BITS-1:0]   m_tdata,
  output logic [DATA_BITS/8-1:0] m_tkeep,
  output logic                   m_tlast,
  output logic                   m_tid,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [31:0]            pkt_cnt0,
  output logic [31:0]            pkt_cnt1
);

  localparam int KEEP_BITS = DATA_BITS / 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic [DATA_BITS-1:0] m_tdata_q;
  logic [KEEP_BITS-1:0] m_tkeep_q;
  logic                 m_tlast_q;
  logic                 m_tid_q;
  logic                 m_tvalid_q;

  logic out_free;
  logic acc0, acc1, acc_any;

  // The output slot can take a beat when it is empty or being drained this cycle.
  assign out_free  = !m_tvalid_q || m_tready;
  assign s0_tready = (state_q == ST_GRANT0) && out_free;
  assign s1_tready = (state_q == ST_GRANT1) && out_free;

  assign acc0    = s0_tvalid && s0_tready;
  assign acc1    = s1_tvalid && s1_tready;
  assign acc_any = acc0 || acc1;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (s0_tvalid && s1_tvalid) begin
          state_d = (prio_mode || !rr_ptr_q) ? ST_GRANT0 : ST_GRANT1;
        end else if (s0_tvalid) begin
          state_d = ST_GRANT0;
        end else if (s1_tvalid) begin
          state_d = ST_GRANT1;
        end
      end
      ST_GRANT0: begin
        if (acc0 && s0_tlast) begin
          state_d  = ST_IDLE;
          rr_ptr_d = 1'b1;
        end
      end
      ST_GRANT1: begin
        if (acc1 && s1_tlast) begin
          state_d  = ST_IDLE;
          rr_ptr_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // NOTE: the output data register is reset too, because a reset must present a zeroed beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tid_q    <= 1'b0;
      m_tvalid_q <= 1'b0;
    end else if (acc_any) begin
      m_tdata_q  <= acc1 ? s1_tdata : s0_tdata;
      m_tkeep_q  <= acc1 ? s1_tkeep : s0_tkeep;
      m_tlast_q  <= acc1 ? s1_tlast : s0_tlast;
      m_tid_q    <= acc1;
      m_tvalid_q <= 1'b1;
    end else if (m_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tlast  = m_tlast_q;
  assign m_tid    = m_tid_q;
  assign m_tvalid = m_tvalid_q;

`ifdef USER_ARB_PKT_CNT_EN
  logic [31:0] pkt_cnt0_q, pkt_cnt1_q;

  // Counters wrap naturally at 32 bits.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      if (acc0 && s0_tlast) pkt_cnt0_q <= pkt_cnt0_q + 32'd1;
      if (acc1 && s1_tlast) pkt_cnt1_q <= pkt_cnt1_q + 32'd1;
    end
  end

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
`else
  assign pkt_cnt0 = '0;
  assign pkt_cnt1 = '0;
`endif

endmodule
